// File: rtl/ppa_pkg.sv
// Shared constants and helpers for the parallel-prefix adder slice.
package ppa_pkg;

  // Default operand/sum width of the NTRU-HRSS coefficient adder.
  localparam int PPA_NUM_BIT = 13;

  // Ceiling log2, used to size the prefix tree (number of levels).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/ppa_prefix_cell.sv
// Prefix combine cell. IS_BLACK=1 produces group generate and propagate;
// IS_BLACK=0 is the grey form (group generate only, po tied low) used where
// the lower operand already spans down to bit 0.
module ppa_prefix_cell
  import ppa_pkg::*;
#(
  parameter bit IS_BLACK = 1'b1
) (
  input  logic gi1,
  input  logic pi1,
  input  logic gi2,
  input  logic pi2,
  output logic go,
  output logic po
);

  // Group generate: upper generates, or upper propagates a lower generate.
  assign go = gi1 | (pi1 & gi2);

  // Group propagate only matters while the span has not yet reached bit 0.
  assign po = IS_BLACK ? (pi1 & pi2) : 1'b0;

endmodule

// File: rtl/ppa_sk_adder.sv
// Registered Sklansky parallel-prefix adder: out = (x1 + x2) mod 2^NUM_BIT,
// with carry out and a valid flag, one cycle of latency.
// Optional carry-in: define PPA_CIN_EN to add a cin port that is injected
// below bit 0 of the prefix tree.
module ppa_sk_adder
  import ppa_pkg::*;
#(
  parameter int NUM_BIT = PPA_NUM_BIT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
`ifdef PPA_CIN_EN
  input  logic               cin,
`endif
  input  logic [NUM_BIT-1:0] x1,
  input  logic [NUM_BIT-1:0] x2,
  output logic               out_valid,
  output logic [NUM_BIT-1:0] out,
  output logic               cout
);

  localparam int LVL = clog2(NUM_BIT);

  logic               cin_eff;
  logic [NUM_BIT-1:0] g0;
  logic [NUM_BIT-1:0] p0;
  logic [NUM_BIT-1:0] sum;
  logic [NUM_BIT-1:0] gl [LVL+1];
  logic [NUM_BIT-1:0] pl [LVL+1];

`ifdef PPA_CIN_EN
  assign cin_eff = cin;
`else
  assign cin_eff = 1'b0;
`endif

  // Half-adder generate/propagate per bit.
  assign g0 = x1 & x2;
  assign p0 = x1 ^ x2;

  // Level 0: fold the carry-in into bit 0 so every later grey cell sees it.
  assign gl[0] = {g0[NUM_BIT-1:1], g0[0] | (p0[0] & cin_eff)};
  assign pl[0] = p0;

  // Sklansky tree: at level k the upper half of each 2^k block combines
  // with the top bit of the lower half of that block.
  for (genvar k = 1; k <= LVL; k++) begin : g_lvl
    for (genvar i = 0; i < NUM_BIT; i++) begin : g_bit
      localparam int BLK  = 1 << k;
      localparam int HALF = 1 << (k - 1);
      localparam int BASE = (i / BLK) * BLK;
      localparam int J    = BASE + HALF - 1;
      if ((i % BLK) >= HALF) begin : g_comb
        logic go_w;
        logic po_w;
        ppa_prefix_cell #(
          .IS_BLACK(BASE != 0)
        ) u_cell (
          .gi1(gl[k-1][i]),
          .pi1(pl[k-1][i]),
          .gi2(gl[k-1][J]),
          .pi2(pl[k-1][J]),
          .go (go_w),
          .po (po_w)
        );
        assign gl[k][i] = go_w;
        assign pl[k][i] = po_w;
      end else begin : g_pass
        assign gl[k][i] = gl[k-1][i];
        assign pl[k][i] = pl[k-1][i];
      end
    end
  end

  // Sum bit i takes the carry out of bits [i-1:0]; bit 0 takes the carry-in.
  assign sum = p0 ^ {gl[LVL][NUM_BIT-2:0], cin_eff};

  // Output register: reset wins, otherwise capture on in_valid and hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out  <= sum;
        cout <= gl[LVL][NUM_BIT-1];
      end
    end
  end

endmodule

// File: tb/tb_ppa_sk_adder.sv
// Self-checking bench for ppa_sk_adder (NUM_BIT = 13). Stimulus is driven on
// the falling edge; the expected register state for each driven cycle is
// queued and compared 1 ns after the following rising edge.
module tb_ppa_sk_adder;

  localparam int N = 13;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         cin_r;
  logic [N-1:0] x1;
  logic [N-1:0] x2;
  logic         out_valid;
  logic [N-1:0] out;
  logic         cout;

  ppa_sk_adder #(
    .NUM_BIT(N)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
`ifdef PPA_CIN_EN
    .cin      (cin_r),
`endif
    .x1       (x1),
    .x2       (x2),
    .out_valid(out_valid),
    .out      (out),
    .cout     (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         v;
    logic [N-1:0] o;
    logic         c;
    string        tag;
  } exp_t;

  typedef struct {
    logic         r;
    logic         iv;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] eo;
    logic         ec;
    logic         ev;
    string        nm;
  } vec_t;

  exp_t         sb[$];
  int           total = 0;
  int           bad = 0;
  logic [N-1:0] m_o = '0;
  logic         m_c = 1'b0;

  // Compare the registered outputs against the oldest queued expectation.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      total++;
      if (out_valid !== e.v || out !== e.o || cout !== e.c) begin
        bad++;
        $display("FAIL %s: got valid=%b out=%h cout=%b, want valid=%b out=%h cout=%b",
                 e.tag, out_valid, out, cout, e.v, e.o, e.c);
      end
    end
  end

  function automatic vec_t mk(input logic r, input logic iv, input logic [N-1:0] a,
                              input logic [N-1:0] b, input logic [N-1:0] eo,
                              input logic ec, input logic ev, input string nm);
    vec_t t;
    t.r = r; t.iv = iv; t.a = a; t.b = b;
    t.eo = eo; t.ec = ec; t.ev = ev; t.nm = nm;
    return t;
  endfunction

  task automatic step(input logic r, input logic iv, input logic [N-1:0] a,
                      input logic [N-1:0] b, input logic c, input exp_t e);
    @(negedge clk);
    rst = r; in_valid = iv; x1 = a; x2 = b; cin_r = c;
    sb.push_back(e);
  endtask

  // Reference model: plain wide addition, hold on idle, clear on reset.
  task automatic step_model(input logic r, input logic iv, input logic [N-1:0] a,
                            input logic [N-1:0] b, input logic c, input string tag);
    exp_t       e;
    logic [N:0] s;
    logic       ce;
`ifdef PPA_CIN_EN
    ce = c;
`else
    ce = 1'b0;
`endif
    if (r) begin
      m_o = '0; m_c = 1'b0; e.v = 1'b0;
    end else if (iv) begin
      s = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, ce};
      m_o = s[N-1:0]; m_c = s[N]; e.v = 1'b1;
    end else begin
      e.v = 1'b0;
    end
    e.o = m_o; e.c = m_c; e.tag = tag;
    step(r, iv, a, b, c, e);
  endtask

  vec_t tv[$];

  initial begin
    exp_t e;
    rst = 1'b1; in_valid = 1'b0; x1 = '0; x2 = '0; cin_r = 1'b0;

    tv.push_back(mk(1, 0, 13'h0000, 13'h0000, 13'h0000, 0, 0, "reset"));
    tv.push_back(mk(0, 1, 13'h1FFF, 13'h0001, 13'h0000, 1, 1, "wrap"));
    tv.push_back(mk(0, 1, 13'h0FFF, 13'h0001, 13'h1000, 0, 1, "carry_chain"));
    tv.push_back(mk(0, 1, 13'h0AAA, 13'h1555, 13'h1FFF, 0, 1, "no_carry"));
    for (int i = 0; i < 3; i++)
      tv.push_back(mk(0, 0, N'($urandom_range(0, 8191)), N'($urandom_range(0, 8191)),
                      13'h1FFF, 0, 0, "idle_hold"));
    tv.push_back(mk(1, 1, 13'h0123, 13'h0456, 13'h0000, 0, 0, "rst_midstream"));
    tv.push_back(mk(0, 0, 13'h0123, 13'h0456, 13'h0000, 0, 0, "hold_after_rst"));
    tv.push_back(mk(0, 1, 13'h0123, 13'h0456, 13'h0579, 0, 1, "after_rst"));
    tv.push_back(mk(0, 1, 13'h1FFF, 13'h1FFF, 13'h1FFE, 1, 1, "max_plus_max"));
    tv.push_back(mk(0, 1, 13'h0000, 13'h0000, 13'h0000, 0, 1, "zero_clears_cout"));
    tv.push_back(mk(0, 1, 13'h1000, 13'h1000, 13'h0000, 1, 1, "msb_only"));
    tv.push_back(mk(0, 1, 13'h00FF, 13'h0F01, 13'h1000, 0, 1, "mixed_chain"));

    foreach (tv[i]) begin
      e.v = tv[i].ev; e.o = tv[i].eo; e.c = tv[i].ec; e.tag = tv[i].nm;
      step(tv[i].r, tv[i].iv, tv[i].a, tv[i].b, 1'b0, e);
      m_o = tv[i].eo; m_c = tv[i].ec;
    end

`ifdef PPA_CIN_EN
    e.v = 1'b1; e.o = 13'h0000; e.c = 1'b1; e.tag = "cin_wrap";
    step(0, 1, 13'h1FFE, 13'h0001, 1'b1, e);
    e.v = 1'b1; e.o = 13'h1000; e.c = 1'b0; e.tag = "cin_chain";
    step(0, 1, 13'h0FFF, 13'h0000, 1'b1, e);
    m_o = 13'h1000; m_c = 1'b0;
`endif

    // Reset landing in the middle of a back-to-back burst, then gaps.
    step_model(0, 1, 13'h1ABC, 13'h0F0F, 1'b1, "burst_a");
    step_model(0, 1, 13'h1FFF, 13'h1FFF, 1'b0, "burst_b");
    step_model(1, 1, 13'h1234, 13'h1234, 1'b1, "burst_rst");
    step_model(0, 1, 13'h0FFF, 13'h1001, 1'b0, "burst_resume");
    step_model(0, 0, 13'h0001, 13'h0001, 1'b1, "burst_gap");
    step_model(0, 1, 13'h0001, 13'h0001, 1'b1, "burst_end");

    // Randomised back-to-back sweep.
    for (int i = 0; i < 10000; i++)
      step_model(0, 1, N'($urandom), N'($urandom), 1'($urandom), "sweep");

    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 5 && sb.size() != 0; i++) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending results, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
